// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared LDPC decoder types, width derivations and magnitude saturation.
package ldpc_pkg;
  typedef enum logic {COLLECT, EMIT} state_t;
  function automatic int sum_w(input int data_w, input int ext_w);
    return data_w + ext_w;
  endfunction
  function automatic int maxmag(input int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction
  function automatic logic [31:0] sat_mag(input logic [31:0] mag, input logic [31:0] lim);
    return mag > lim ? lim : mag;
  endfunction
endpackage

// File: rtl/cnu_sm_conv.sv
// cnu_sm_conv: two's complement sum to {sign, saturated magnitude}, combinational.
module cnu_sm_conv
  import ldpc_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int SUM_W  = 9
) (
  input  logic [SUM_W-1:0]  q,
  output logic              sgn,
  output logic [DATA_W-2:0] mag
);
  logic [SUM_W-1:0] a;
  // the most negative input negates to itself, which reads correctly as unsigned
  assign a   = q[SUM_W-1] ? -q : q;
  assign sgn = q[SUM_W-1];
  assign mag = (DATA_W-1)'(sat_mag(32'(a), 32'(maxmag(DATA_W))));
endmodule

// File: rtl/cnu_serial.sv
// cnu_serial: serial min-sum check node unit; OFFSET_MS_EN selects offset min-sum.
module cnu_serial
  import ldpc_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int EXT_W  = 3,
  parameter int DC     = 6,
`ifdef OFFSET_MS_EN
  parameter int OFFSET = 1,
`endif
  localparam int SUM_W = sum_w(DATA_W, EXT_W),
  localparam int IDX_W = $clog2(DC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SUM_W-1:0]  q_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] r_out,
  output logic [IDX_W-1:0]  r_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_ok
);
  localparam logic [DATA_W-2:0] MAXM = (DATA_W-1)'(maxmag(DATA_W));
  state_t state, state_n;
  logic [IDX_W-1:0] cnt, min_idx;
  logic [DATA_W-2:0] min1, min2, q_mag, m, mo;
  logic [DC-1:0] sgn;
  logic sgn_par, q_sgn, in_beat, out_beat, last, s;
  logic [DATA_W-1:0] r;
  cnu_sm_conv #(.DATA_W(DATA_W), .SUM_W(SUM_W)) u_conv (
    .q  (q_in),
    .sgn(q_sgn),
    .mag(q_mag)
  );
  always_comb begin
    in_ready  = state == COLLECT && !rst;
    out_valid = state == EMIT;
    in_beat   = in_valid && in_ready;
    out_beat  = out_valid && out_ready;
    last      = cnt == IDX_W'(DC - 1);
    state_n   = state == COLLECT ? (in_beat && last ? EMIT : COLLECT)
                                 : (out_beat && last ? COLLECT : EMIT);
    m         = cnt == min_idx ? min2 : min1;
    s         = sgn_par ^ sgn[cnt];
`ifdef OFFSET_MS_EN
    mo        = m > (DATA_W-1)'(OFFSET) ? m - (DATA_W-1)'(OFFSET) : '0;
`else
    mo        = m;
`endif
    r         = s ? -{1'b0, mo} : {1'b0, mo};
    r_out     = out_valid ? r : '0;
    r_idx     = out_valid ? cnt : '0;
    parity_ok = out_valid && !sgn_par;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= COLLECT;
      cnt     <= '0;
      min1    <= MAXM;
      min2    <= MAXM;
      min_idx <= '0;
      sgn_par <= 1'b0;
      sgn     <= '0;
    end else begin
      state <= state_n;
      if (in_beat) begin
        sgn[cnt] <= q_sgn;
        sgn_par  <= sgn_par ^ q_sgn;
        cnt      <= last ? '0 : cnt + 1'b1;
        if (q_mag < min1) begin
          min2    <= min1;
          min1    <= q_mag;
          min_idx <= cnt;
        end else if (q_mag < min2) begin
          min2 <= q_mag;
        end
      end
      if (out_beat) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          min1    <= MAXM;
          min2    <= MAXM;
          sgn_par <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cnu_serial.sv
// tb_cnu_serial: directed self-checking bench for cnu_serial (OFFSET_MS_EN selects offset vectors).
module tb_cnu_serial;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [8:0] q_in = '0;
  logic in_ready, out_valid, parity_ok;
  logic [5:0] r_out;
  logic [2:0] r_idx;
  int checks = 0, failures = 0;
  logic [8:0] qa [6];
  logic [5:0] ea [6];
  cnu_serial dut (
    .clk(clk), .rst(rst), .q_in(q_in), .in_valid(in_valid), .in_ready(in_ready),
    .r_out(r_out), .r_idx(r_idx), .out_valid(out_valid), .out_ready(out_ready),
    .parity_ok(parity_ok)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL send_in_ready beat=%0d got=%b want=1", i, in_ready);
      end
      in_valid = 1;
      q_in = qa[i];
      step();
    end
    in_valid = 0;
    q_in = 9'h1aa;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL latency out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
    end
  endtask
  task automatic test_block(input string name, input logic par);
    send();
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || r_idx !== 3'(i) || r_out !== ea[i] || parity_ok !== par) begin
        failures++;
        $display("FAIL %s idx=%0d got v=%b i=%0d r=%0d p=%b want v=1 i=%0d r=%0d p=%b", name, i,
                 out_valid, r_idx, $signed(r_out), parity_ok, i, $signed(ea[i]), par);
      end
      step();
    end
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_done out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask
  task automatic test_reset();
    rst = 1;
    step();
    step();
    checks++;
    if (out_valid !== 0 || r_out !== 0 || r_idx !== 0 || parity_ok !== 0 || in_ready !== 0) begin
      failures++;
      $display("FAIL reset_hold v=%b r=%0d i=%0d p=%b rdy=%b want all 0", out_valid, r_out, r_idx, parity_ok, in_ready);
    end
    rst = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready=%b want 1", in_ready);
    end
  endtask
  task automatic load_t1();
    qa = '{9'd5, -9'sd3, 9'd7, 9'd2, 9'd9, -9'sd4};
    ea = '{6'd2, -6'sd2, 6'd2, 6'd3, 6'd2, -6'sd2};
  endtask
  task automatic test_stall();
    load_t1();
    send();
    out_ready = 1;
    step();
    step();
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1 || r_idx !== 3'd2 || r_out !== 6'd2 || in_ready !== 0) begin
        failures++;
        $display("FAIL stall c=%0d got v=%b i=%0d r=%0d rdy=%b want 1/2/2/0", c, out_valid, r_idx, r_out, in_ready);
      end
      in_valid = 1;
      step();
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 2; i < 6; i++) begin
      checks++;
      if (out_valid !== 1 || r_idx !== 3'(i) || r_out !== ea[i] || parity_ok !== 1) begin
        failures++;
        $display("FAIL stall_resume idx=%0d got i=%0d r=%0d want r=%0d", i, r_idx, $signed(r_out), $signed(ea[i]));
      end
      step();
    end
    out_ready = 0;
    checks++;
    if (out_valid !== 0 || in_ready !== 1) begin
      failures++;
      $display("FAIL stall_done out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask
  task automatic test_mid_reset();
    load_t1();
    send();
    out_ready = 1;
    step();
    step();
    out_ready = 0;
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++;
    if (out_valid !== 0 || in_ready !== 1 || r_out !== 0 || r_idx !== 0) begin
      failures++;
      $display("FAIL mid_reset out_valid=%b in_ready=%b r=%0d i=%0d want 0/1/0/0", out_valid, in_ready, r_out, r_idx);
    end
    test_block("after_reset", 1'b1);
  endtask
  initial begin
    test_reset();
`ifdef OFFSET_MS_EN
    qa = '{9'd5, -9'sd3, 9'd7, 9'd2, 9'd9, -9'sd4};
    ea = '{6'd1, -6'sd1, 6'd1, 6'd2, 6'd1, -6'sd1};
    test_block("offset_basic", 1'b1);
    qa = '{9'd1, 9'd1, 9'd1, 9'd1, 9'd1, 9'd1};
    ea = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    test_block("offset_ones", 1'b1);
`else
    load_t1();
    test_block("basic", 1'b1);
    qa = '{-9'sd256, 9'd100, 9'd100, 9'd100, 9'd100, 9'd100};
    ea = '{6'd31, -6'sd31, -6'sd31, -6'sd31, -6'sd31, -6'sd31};
    test_block("saturate", 1'b0);
    qa = '{9'd4, 9'd4, 9'd4, 9'd4, 9'd4, 9'd4};
    ea = '{6'd4, 6'd4, 6'd4, 6'd4, 6'd4, 6'd4};
    test_block("ties", 1'b1);
    qa = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
    ea = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    test_block("zeros", 1'b1);
    test_stall();
    test_mid_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
